// File: rtl/jedro_1_alu_arbiter.sv
// Two-port arbiter in front of the shared combinational jedro_1 ALU: one request in flight,
// registered ALU inputs, result returned on a valid/ready channel. Build macro: JEDRO_1_ALU_ARB_FIXED_PRIO_EN.
module jedro_1_alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 4,
   parameter int ID_WIDTH   = 3
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [1:0]            req_valid_i,
   output logic [1:0]            req_ready_o,
   input  logic [OP_WIDTH-1:0]   req_op0_i,
   input  logic [OP_WIDTH-1:0]   req_op1_i,
   input  logic [DATA_WIDTH-1:0] req_opa0_i,
   input  logic [DATA_WIDTH-1:0] req_opa1_i,
   input  logic [DATA_WIDTH-1:0] req_opb0_i,
   input  logic [DATA_WIDTH-1:0] req_opb1_i,
   input  logic [ID_WIDTH-1:0]   req_id0_i,
   input  logic [ID_WIDTH-1:0]   req_id1_i,
   output logic [OP_WIDTH-1:0]   alu_op_sel_o,
   output logic [DATA_WIDTH-1:0] alu_opa_o,
   output logic [DATA_WIDTH-1:0] alu_opb_o,
   input  logic [DATA_WIDTH-1:0] alu_res_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_port_o,
   output logic [ID_WIDTH-1:0]   rsp_id_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                  state_reg, state_next;
   logic                    last_grant_reg;
   logic [OP_WIDTH-1:0]     op_reg;
   logic [DATA_WIDTH-1:0]   opa_reg;
   logic [DATA_WIDTH-1:0]   opb_reg;
   logic [ID_WIDTH-1:0]     id_reg;
   logic                    port_reg;
   logic [DATA_WIDTH-1:0]   data_reg;

   logic                    grant_valid;
   logic                    grant_port;

   always_comb begin
      state_next  = state_reg;
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      req_ready_o = 2'b00;
      case (state_reg)
         IDLE: begin
            if (req_valid_i == 2'b11) begin
`ifdef JEDRO_1_ALU_ARB_FIXED_PRIO_EN
               grant_port = 1'b0;
`else
               grant_port = ~last_grant_reg;
`endif
            end else begin
               grant_port = req_valid_i[1];
            end
            grant_valid = |req_valid_i;
            if (grant_valid) begin
               req_ready_o = grant_port ? 2'b10 : 2'b01;
               state_next  = EXEC;
            end
         end
         EXEC: state_next = RESP;
         RESP: begin
            if (rsp_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Issue registers feed the ALU directly and keep their value until the next grant.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         op_reg         <= '0;
         opa_reg        <= '0;
         opb_reg        <= '0;
         id_reg         <= '0;
         port_reg       <= 1'b0;
         data_reg       <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && grant_valid) begin
            op_reg         <= grant_port ? req_op1_i  : req_op0_i;
            opa_reg        <= grant_port ? req_opa1_i : req_opa0_i;
            opb_reg        <= grant_port ? req_opb1_i : req_opb0_i;
            id_reg         <= grant_port ? req_id1_i  : req_id0_i;
            port_reg       <= grant_port;
            last_grant_reg <= grant_port;
         end
         if (state_reg == EXEC) data_reg <= alu_res_i;
      end
   end

   assign alu_op_sel_o = op_reg;
   assign alu_opa_o    = opa_reg;
   assign alu_opb_o    = opb_reg;
   assign rsp_valid_o  = (state_reg == RESP);
   assign rsp_port_o   = port_reg;
   assign rsp_id_o     = id_reg;
   assign rsp_data_o   = data_reg;
   assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_jedro_1_alu_arbiter.sv
// Bench for jedro_1_alu_arbiter: behavioural ALU stand-in, transaction-level reference model,
// directed scenarios followed by a randomized phase.
module tb_jedro_1_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd4, OP_SRA = 4'd7;

   logic        clk, rstn;
   logic [1:0]  req_valid, req_ready;
   logic [3:0]  req_op0, req_op1, alu_op_sel;
   logic [31:0] req_opa0, req_opa1, req_opb0, req_opb1;
   logic [2:0]  req_id0, req_id1, rsp_id;
   logic [31:0] alu_opa, alu_opb, alu_res, rsp_data;
   logic        rsp_valid, rsp_ready, rsp_port, busy;

   jedro_1_alu_arbiter dut (
      .clk_i(clk), .rstn_i(rstn),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op0_i(req_op0), .req_op1_i(req_op1),
      .req_opa0_i(req_opa0), .req_opa1_i(req_opa1),
      .req_opb0_i(req_opb0), .req_opb1_i(req_opb1),
      .req_id0_i(req_id0), .req_id1_i(req_id1),
      .alu_op_sel_o(alu_op_sel), .alu_opa_o(alu_opa), .alu_opb_o(alu_opb),
      .alu_res_i(alu_res),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_port_o(rsp_port), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
      .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res = alu_f(alu_op_sel, alu_opa, alu_opb);

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  id;
   } txn_t;

   txn_t        pend0[$], pend1[$];
   int          served[$];
   logic [31:0] got[$];
   bit          m_busy;
   int          m_age, m_last, m_port;
   txn_t        m_txn;
   bit          gate0, gate1, rr;
   int          chk_cnt, pass_cnt, fail_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input bit v0, input bit v1, input int last);
      if (v0 && v1) begin
`ifdef JEDRO_1_ALU_ARB_FIXED_PRIO_EN
         return 0;
`else
         return (last == 0) ? 1 : 0;
`endif
      end
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic push(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] id);
      txn_t t;
      t.op = op; t.a = a; t.b = b; t.id = id;
      if (p == 0) pend0.push_back(t);
      else pend1.push_back(t);
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_age = 0; m_last = 1;
      pend0.delete(); pend1.delete();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_op"}, alu_op_sel, 0);
      chk({tag, "_opa"}, alu_opa, 0);
      chk({tag, "_opb"}, alu_opb, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_port"}, rsp_port, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // One clock cycle: drive at posedge+1, check at posedge+2, advance the model after the edge.
   task automatic step();
      int p;
      logic [1:0] exp_ready;
      req_valid = {gate1 && (pend1.size() > 0), gate0 && (pend0.size() > 0)};
      if (pend0.size() > 0) begin
         req_op0 = pend0[0].op; req_opa0 = pend0[0].a; req_opb0 = pend0[0].b; req_id0 = pend0[0].id;
      end
      if (pend1.size() > 0) begin
         req_op1 = pend1[0].op; req_opa1 = pend1[0].a; req_opb1 = pend1[0].b; req_id1 = pend1[0].id;
      end
      rsp_ready = rr;
      #1;
      p = m_busy ? -1 : pick(req_valid[0], req_valid[1], m_last);
      exp_ready = (p < 0) ? 2'b00 : ((p == 0) ? 2'b01 : 2'b10);
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_age >= 1);
      if (m_busy) begin
         chk("alu_op", alu_op_sel, m_txn.op);
         chk("alu_opa", alu_opa, m_txn.a);
         chk("alu_opb", alu_opb, m_txn.b);
         if (m_age >= 1) begin
            chk("rsp_data", rsp_data, alu_f(m_txn.op, m_txn.a, m_txn.b));
            chk("rsp_id", rsp_id, m_txn.id);
            chk("rsp_port", rsp_port, m_port);
            if (rr) got.push_back(rsp_data);
         end
      end
      @(posedge clk);
      #1;
      if (p >= 0) begin
         if (p == 0) begin m_txn = pend0[0]; void'(pend0.pop_front()); end
         else begin m_txn = pend1[0]; void'(pend1.pop_front()); end
         m_busy = 1'b1; m_age = 0; m_last = p; m_port = p;
         served.push_back(p);
      end else if (m_busy) begin
         if (m_age >= 1 && rr) m_busy = 1'b0;
         else m_age++;
      end
   endtask

   task automatic apply_reset(input string tag);
      rstn = 1'b0;
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      check_zero_outputs(tag);
      chk({tag, "_ready"}, req_ready, 2'b00);
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      rr = 1'b1; gate0 = 1'b1; gate1 = 1'b1;
      while ((pend0.size() > 0 || pend1.size() > 0 || m_busy) && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_drain_timeout"}, (pend0.size() > 0 || pend1.size() > 0 || m_busy), 0);
   endtask

   initial begin
      int base;
      chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
      rstn = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      req_op0 = '0; req_op1 = '0; req_opa0 = '0; req_opa1 = '0;
      req_opb0 = '0; req_opb1 = '0; req_id0 = '0; req_id1 = '0;
      gate0 = 1'b1; gate1 = 1'b1; rr = 1'b1;
      model_reset();
      #3;
      apply_reset("reset");

      // Single port 0 ADD
      push(0, OP_ADD, 32'd5, 32'd7, 3'd3);
      drain("t1");
      chk("t1_add_result", got[$], 32'd12);

      // Both ports from reset, then both again
      apply_reset("t2_reset");
      push(0, OP_SUB, 32'd10, 32'd3, 3'd1);
      push(1, OP_XOR, 32'hF0, 32'h0F, 3'd2);
      base = served.size();
      drain("t2a");
      chk("t2_first_port", served[base], 0);
      chk("t2_sub_result", got[got.size()-2], 32'd7);
      chk("t2_xor_result", got[$], 32'hFF);
      push(0, OP_ADD, 32'd1, 32'd2, 3'd4);
      push(1, OP_ADD, 32'd3, 32'd4, 3'd5);
      base = served.size();
      drain("t2b");
      chk("t2_repeat_first_port", served[base], 0);

      // Backpressure with a competing request pending
      push(0, OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 3'd6);
      rr = 1'b0;
      step(); step();
      push(1, OP_SUB, 32'd100, 32'd1, 3'd7);
      repeat (4) step();
      rr = 1'b1;
      drain("t3");

      // Continuous requests on both ports
      apply_reset("t4_reset");
      for (int k = 0; k < 4; k++) begin
         push(0, OP_ADD, 32'(k), 32'd10, 3'(k));
         push(1, OP_SUB, 32'd50, 32'(k), 3'(4 + k));
      end
      base = served.size();
      repeat (12) step();
      chk("t4_grant_count", served.size() - base, 4);
      if (served.size() >= base + 4) begin
         for (int k = 0; k < 4; k++) begin
`ifdef JEDRO_1_ALU_ARB_FIXED_PRIO_EN
            chk($sformatf("t4_grant%0d", k), served[base+k], 0);
`else
            chk($sformatf("t4_grant%0d", k), served[base+k], k % 2);
`endif
         end
      end
      drain("t4");

      // Reset during EXEC
      push(0, OP_ADD, 32'd9, 32'd9, 3'd2);
      step();
      #2 rstn = 1'b0;
      #1 check_zero_outputs("t5_async");
      @(posedge clk);
      #1 rstn = 1'b1;
      model_reset();
      repeat (4) step();
      push(1, OP_ADD, 32'd20, 32'd22, 3'd1);
      drain("t5");
      chk("t5_fresh_result", got[$], 32'd42);

      // SRA with held response
      push(0, OP_SRA, 32'h80000000, 32'd4, 3'd0);
      rr = 1'b0;
      repeat (4) step();
      rr = 1'b1;
      drain("t6");
      chk("t6_sra_result", got[$], 32'hF8000000);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0 && pend0.size() < 4)
            push(0, 4'($urandom_range(0, 9)), $urandom, $urandom, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0 && pend1.size() < 4)
            push(1, 4'($urandom_range(0, 9)), $urandom, $urandom, 3'($urandom_range(0, 7)));
         gate0 = ($urandom_range(0, 4) != 0);
         gate1 = ($urandom_range(0, 4) != 0);
         rr    = ($urandom_range(0, 3) != 0);
         step();
      end
      drain("rand");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/jedro_1_alu_arbiter.md
Name: jedro_1_alu_arbiter

Overview:
Shares the single combinational jedro_1_alu between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare path. Each request carries op, two operands and an id. The arbiter grants one request, registers its operands onto the ALU inputs, captures the result a cycle later and returns it through a valid/ready response channel. It sits between the decode/execute logic and the jedro_1_alu instance. It owns all ALU input sequencing.

Parameters:
DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH)
OP_WIDTH, 4, ALU op select width (matches `ALU_OP_WIDTH)
ID_WIDTH, 3, requester tag width, returned unchanged with the result

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  reset, asynchronous, active-low
req_valid_i  in  2  per-port request valid (bit i = port i)
req_ready_o  out  2  per-port request accepted this cycle
req_op0_i / req_op1_i  in  OP_WIDTH  ALU op per port
req_opa0_i / req_opa1_i  in  DATA_WIDTH  operand A per port
req_opb0_i / req_opb1_i  in  DATA_WIDTH  operand B per port
req_id0_i / req_id1_i  in  ID_WIDTH  tag per port
alu_op_sel_o  out  OP_WIDTH  to ALU alu_op_sel_i
alu_opa_o  out  DATA_WIDTH  to ALU opa_i
alu_opb_o  out  DATA_WIDTH  to ALU opb_i
alu_res_i  in  DATA_WIDTH  from ALU res_o
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  consumer accepts result
rsp_port_o  out  1  port that issued the result
rsp_id_o  out  ID_WIDTH  tag of the result
rsp_data_o  out  DATA_WIDTH  result
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rstn_i low, asynchronous): state=IDLE; all registered outputs are 0 (alu_op_sel_o, alu_opa_o, alu_opb_o, rsp_*, busy_o); last_grant=1, so port 0 wins the first conflict.
- FSM states: IDLE, EXEC, RESP. There is exactly one request in flight at a time.
- IDLE:
  - req_ready_o is combinational. Only the selected port sees ready=1. If no valid is asserted, req_ready_o=2'b00.
  - Selection: if one valid, that port. If both valid, the port != last_grant (round-robin).
  - On valid&ready: latch op/opa/opb/id into issue registers, which drive alu_*_o directly. Record the port, set last_grant=port, go to EXEC.
- EXEC: the ALU inputs are stable for the full cycle. At the clock edge, capture alu_res_i into rsp_data_o and go to RESP. req_ready_o=0.
- RESP:
  - rsp_valid_o=1, with rsp_port_o/rsp_id_o/rsp_data_o held stable until rsp_ready_i.
  - On rsp_valid&rsp_ready: rsp_valid_o=0 next cycle and the state returns to IDLE.
  - If rsp_ready_i is tied high, latency is accept→rsp_valid = 2 cycles and throughput is 1 op per 3 cycles.
- alu_*_o hold their last issued values outside EXEC; they do not return to 0.
- Requester contract: valid and payload stay stable until ready. Dropping valid before ready is allowed and results in no grant, with last_grant unchanged.
- Ops are passed through unchecked. An undefined op yields whatever the ALU returns (0 from its default branch).
- Simultaneous req valid and rsp handshake in RESP: the request is not accepted that cycle; it is granted in the following IDLE cycle.
- Reset mid-operation discards the in-flight request; no response is produced.

Optional Feature:
JEDRO_1_ALU_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins when both are valid; last_grant is not used for selection. Port 1 may starve; this is intended for the debug/bring-up configuration.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single port 0 request op=ALU_OP_ADD, opa=5, opb=7, id=3, rsp_ready_i=1 → req_ready_o=01 in the same cycle; two cycles later rsp_valid_o=1, rsp_data_o=12, rsp_id_o=3, rsp_port_o=0.
- Both ports valid at once from reset: port 0 ALU_OP_SUB 10-3, port 1 ALU_OP_XOR 0xF0^0x0F → port 0 is served first (rsp_data_o=7), then port 1 (0xFF). Repeat with both valid again → port 0 is served first again, because last_grant=1 after port 1. With the macro defined, port 0 always goes first.
- Backpressure: rsp_ready_i=0 for 4 cycles after rsp_valid_o rises → rsp_* stay stable, busy_o=1, req_ready_o=00 throughout; rsp_ready_i=1 → IDLE on the next cycle.
- Continuous requests on both ports for 12 cycles (default build) → 4 grants alternating 0,1,0,1, in id order per port.
- Assert rstn_i low during EXEC → all outputs 0 immediately (asynchronous), no rsp_valid_o after release; a fresh request then completes normally.
- op=ALU_OP_SRA, opa=0x80000000, opb=4 → rsp_data_o equals the ALU output sampled in EXEC, and alu_opa_o/alu_opb_o/alu_op_sel_o stay constant across EXEC and RESP.
